// File: rtl/mtr_drv_pkg.sv
// Shared constants, types and speed-to-duty helpers for the motor-drive back end.
package mtr_drv_pkg;

  localparam int PWM_W     = 11;
  localparam int OVR_CNT_W = 5;

  typedef logic [PWM_W-1:0] pwm_cnt_t;

  typedef struct packed {
    logic pwm1;
    logic pwm2;
  } pwm_pair_t;

  localparam pwm_cnt_t                 PWM_MID    = 11'd1024;
  localparam pwm_cnt_t                 NONOVERLAP = 11'h020;
  localparam pwm_cnt_t                 BLANK      = 11'd128;
  localparam pwm_cnt_t                 QUAL_START = NONOVERLAP + BLANK;
  localparam logic [OVR_CNT_W-1:0]     OVR_LIMIT  = 5'd16;
  localparam logic signed [11:0]       SPD_MAX    = 12'sd1023;
  localparam logic signed [11:0]       SPD_MIN    = -12'sd1024;

  function automatic logic signed [PWM_W-1:0] sat_spd(input logic signed [11:0] spd);
    logic signed [PWM_W-1:0] res;
    if (spd > SPD_MAX) begin
      res = SPD_MAX[PWM_W-1:0];
    end else if (spd < SPD_MIN) begin
      res = SPD_MIN[PWM_W-1:0];
    end else begin
      res = spd[PWM_W-1:0];
    end
    return res;
  endfunction

  // Offsetting by mid-scale maps -1024..+1023 onto 0..2047.
  function automatic pwm_cnt_t spd_to_duty(input logic signed [11:0] spd);
    return $unsigned(sat_spd(spd)) + PWM_MID;
  endfunction

endpackage

// File: rtl/mtr_drv_pwm_dt.sv
// One H-bridge half-leg: period-latched duty register, dead-time PWM pair
// and leading-edge-blanked over-current qualification.
module pwm_dt
  import mtr_drv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  pwm_cnt_t            cnt,
  input  logic signed [11:0]  spd,
  input  logic                shtdwn,
  input  logic                ovr_i,
  output logic                pwm1,
  output logic                pwm2,
  output logic                ovr_qual
);

  pwm_cnt_t       duty_d, duty_q;
  pwm_pair_t      drv_d, drv_q;
  logic [PWM_W:0] pwm2_start;

  // The low side starts one dead-time after duty; a start beyond 2047
  // simply never matches, so the low side stays off for that period.
  always_comb begin
    duty_d = duty_q;
    if (cnt == '1) begin
      duty_d = spd_to_duty(spd);
    end
    pwm2_start = {1'b0, duty_q} + {1'b0, NONOVERLAP};
    drv_d.pwm1 = !shtdwn && (cnt >= NONOVERLAP) && (cnt < duty_q);
    drv_d.pwm2 = !shtdwn && ({1'b0, cnt} >= pwm2_start);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= PWM_MID;
      drv_q  <= '0;
    end else begin
      duty_q <= duty_d;
      drv_q  <= drv_d;
    end
  end

  assign pwm1     = drv_q.pwm1;
  assign pwm2     = drv_q.pwm2;
  assign ovr_qual = ovr_i && drv_q.pwm1 && (cnt >= QUAL_START);

endmodule

// File: rtl/mtr_drv.sv
// Motor-drive back end: shared period counter, two dead-time PWM legs and
// the persistent over-current shutdown latch.
module mtr_drv
  import mtr_drv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  input  logic               OVR_I_lft,
  input  logic               OVR_I_rght,
  output logic               PWM1_lft,
  output logic               PWM2_lft,
  output logic               PWM1_rght,
  output logic               PWM2_rght,
  output logic               PWM_synch,
  output logic               OVR_I_shtdwn
);

  pwm_cnt_t               cnt_d, cnt_q;
  logic                   synch_d, synch_q;
  logic                   ovr_seen_d, ovr_seen_q;
  logic [OVR_CNT_W-1:0]   ocnt_d, ocnt_q;
  logic                   shtdwn_d, shtdwn_q;
  logic                   qual_lft, qual_rght;
  logic                   ovr_now, period_end;

  // A period counts as faulty if either leg qualified an event anywhere in it,
  // including on the very last count; one clean period restarts the run.
  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    synch_d    = (cnt_q == '0);
    period_end = (cnt_q == '1);
    ovr_now    = qual_lft || qual_rght;
    ovr_seen_d = ovr_seen_q || ovr_now;
    ocnt_d     = ocnt_q;
    if (period_end) begin
      ovr_seen_d = 1'b0;
      if (ovr_seen_q || ovr_now) begin
        ocnt_d = (ocnt_q >= OVR_LIMIT) ? ocnt_q : ocnt_q + 1'b1;
      end else begin
        ocnt_d = '0;
      end
    end
    shtdwn_d = shtdwn_q || (ocnt_q >= OVR_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      synch_q    <= 1'b0;
      ovr_seen_q <= 1'b0;
      ocnt_q     <= '0;
      shtdwn_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      synch_q    <= synch_d;
      ovr_seen_q <= ovr_seen_d;
      ocnt_q     <= ocnt_d;
      shtdwn_q   <= shtdwn_d;
    end
  end

  // Legs see the next shutdown state so the drives drop with the flag.
  pwm_dt u_lft (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt_q),
    .spd      (lft_spd),
    .shtdwn   (shtdwn_d),
    .ovr_i    (OVR_I_lft),
    .pwm1     (PWM1_lft),
    .pwm2     (PWM2_lft),
    .ovr_qual (qual_lft)
  );

  pwm_dt u_rght (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt_q),
    .spd      (rght_spd),
    .shtdwn   (shtdwn_d),
    .ovr_i    (OVR_I_rght),
    .pwm1     (PWM1_rght),
    .pwm2     (PWM2_rght),
    .ovr_qual (qual_rght)
  );

  assign PWM_synch    = synch_q;
  assign OVR_I_shtdwn = shtdwn_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv: period-level reference model plus
// scenario tasks for duty, dead-time, blanking, fault run and reset.
module tb_mtr_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] lft_spd, rght_spd;
  logic        OVR_I_lft, OVR_I_rght;
  logic        PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, PWM_synch, OVR_I_shtdwn;

  int total_cmp = 0;
  int bad_cmp   = 0;

  // reference model state: counter value the DUT holds, duties in force,
  // consecutive faulty periods, and the expected registered outputs
  int   m_cnt, m_dl, m_dr, m_run;
  logic m_fault, m_shut;
  logic e_p1l, e_p2l, e_p1r, e_p2r, e_sync;

  int          trace_err = 0;
  int          te_cnt;
  logic [5:0]  te_obs, te_exp;

  int n1l, f1l, l1l, n2l, f2l, l2l, n1r, n2r, f2r, l2r, n_ovl, n_sync, sync_i, n_sh;

  mtr_drv dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .OVR_I_lft    (OVR_I_lft),
    .OVR_I_rght   (OVR_I_rght),
    .PWM1_lft     (PWM1_lft),
    .PWM2_lft     (PWM2_lft),
    .PWM1_rght    (PWM1_rght),
    .PWM2_rght    (PWM2_rght),
    .PWM_synch    (PWM_synch),
    .OVR_I_shtdwn (OVR_I_shtdwn)
  );

  always #5 clk = ~clk;

  function automatic int duty_of(input logic [11:0] s);
    int v;
    v = int'($signed(s));
    if (v > 1023) v = 1023;
    if (v < -1024) v = -1024;
    return v + 1024;
  endfunction

  function automatic logic [5:0] obs_vec();
    return {PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, PWM_synch, OVR_I_shtdwn};
  endfunction

  // Advance one clock: model the edge from the pre-edge inputs, then sample
  // the DUT 1 time unit after the edge and log any trace difference.
  task automatic tick();
    int   c;
    logic q, nsh;
    c = m_cnt;
    if (!rst_n) begin
      m_cnt = 0; m_dl = 1024; m_dr = 1024; m_run = 0;
      m_fault = 1'b0; m_shut = 1'b0;
      {e_p1l, e_p2l, e_p1r, e_p2r, e_sync} = '0;
    end else begin
      q   = (OVR_I_lft && e_p1l && c >= 160) || (OVR_I_rght && e_p1r && c >= 160);
      nsh = m_shut || (m_run >= 16);
      e_p1l  = !nsh && c >= 32 && c < m_dl;
      e_p2l  = !nsh && c >= m_dl + 32;
      e_p1r  = !nsh && c >= 32 && c < m_dr;
      e_p2r  = !nsh && c >= m_dr + 32;
      e_sync = (c == 0);
      if (c == 2047) begin
        m_run   = (m_fault || q) ? m_run + 1 : 0;
        m_fault = 1'b0;
        m_dl    = duty_of(lft_spd);
        m_dr    = duty_of(rght_spd);
      end else begin
        m_fault = m_fault || q;
      end
      m_shut = nsh;
      m_cnt  = (c + 1) % 2048;
    end
    @(posedge clk);
    #1;
    if (obs_vec() !== {e_p1l, e_p2l, e_p1r, e_p2r, e_sync, m_shut}) begin
      if (trace_err == 0) begin
        te_cnt = c;
        te_obs = obs_vec();
        te_exp = {e_p1l, e_p2l, e_p1r, e_p2r, e_sync, m_shut};
      end
      trace_err++;
    end
  endtask

  // One full period starting at cnt 0; i equals the count that produced the
  // outputs seen after each tick. Optional speed change and over-current pulses.
  task automatic measure_period(input int chg_at, input logic [11:0] nl, input logic [11:0] nr,
                                input int ol_a, input int ol_b, input int or_a);
    n1l = 0; n2l = 0; n1r = 0; n2r = 0; n_ovl = 0; n_sync = 0; n_sh = 0;
    f1l = -1; l1l = -1; f2l = -1; l2l = -1; f2r = -1; l2r = -1; sync_i = -1;
    for (int i = 0; i < 2048; i++) begin
      if (i == chg_at) begin
        lft_spd  = nl;
        rght_spd = nr;
      end
      OVR_I_lft  = (i == ol_a) || (i == ol_b);
      OVR_I_rght = (i == or_a);
      tick();
      if (PWM1_lft)  begin n1l++; if (f1l < 0) f1l = i; l1l = i; end
      if (PWM2_lft)  begin n2l++; if (f2l < 0) f2l = i; l2l = i; end
      if (PWM1_rght) n1r++;
      if (PWM2_rght) begin n2r++; if (f2r < 0) f2r = i; l2r = i; end
      if ((PWM1_lft && PWM2_lft) || (PWM1_rght && PWM2_rght)) n_ovl++;
      if (PWM_synch) begin n_sync++; sync_i = i; end
      if (OVR_I_shtdwn) n_sh++;
    end
    OVR_I_lft  = 1'b0;
    OVR_I_rght = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lft_spd = 12'($urandom); rght_spd = 12'($urandom);
    OVR_I_lft = 1'b0; OVR_I_rght = 1'b0;
    repeat (3) tick();
    total_cmp++; if (obs_vec() !== 6'b0) begin bad_cmp++; $display("[TB] FAIL reset_outputs: got %b want 000000", obs_vec()); end
    rst_n = 1'b1;
    measure_period(1000, 12'd0, 12'd0, -1, -1, -1);
    total_cmp++; if (n1l !== 992) begin bad_cmp++; $display("[TB] FAIL first_period_p1l: got %0d want 992", n1l); end
    total_cmp++; if (n2r !== 992) begin bad_cmp++; $display("[TB] FAIL first_period_p2r: got %0d want 992", n2r); end
    total_cmp++; if (sync_i !== 0) begin bad_cmp++; $display("[TB] FAIL first_sync_pos: got %0d want 0", sync_i); end
    total_cmp++; if (trace_err !== 0) begin bad_cmp++; $display("[TB] FAIL reset_trace: %0d cycles differ, first at cnt=%0d got=%b want=%b", trace_err, te_cnt, te_obs, te_exp); end
    trace_err = 0;
  endtask

  task automatic test_zero_speed();
    measure_period(700, 12'd1023, 12'h800, -1, -1, -1);
    total_cmp++; if (n1l !== 992)  begin bad_cmp++; $display("[TB] FAIL zero_p1l_count: got %0d want 992", n1l); end
    total_cmp++; if (f1l !== 32)   begin bad_cmp++; $display("[TB] FAIL zero_p1l_rise: got %0d want 32", f1l); end
    total_cmp++; if (l1l !== 1023) begin bad_cmp++; $display("[TB] FAIL zero_p1l_last: got %0d want 1023", l1l); end
    total_cmp++; if (n2l !== 992)  begin bad_cmp++; $display("[TB] FAIL zero_p2l_count: got %0d want 992", n2l); end
    total_cmp++; if (f2l !== 1056) begin bad_cmp++; $display("[TB] FAIL zero_p2l_rise: got %0d want 1056", f2l); end
    total_cmp++; if (l2l !== 2047) begin bad_cmp++; $display("[TB] FAIL zero_p2l_last: got %0d want 2047", l2l); end
    total_cmp++; if (n1r !== 992)  begin bad_cmp++; $display("[TB] FAIL zero_p1r_count: got %0d want 992", n1r); end
    total_cmp++; if (n2r !== 992)  begin bad_cmp++; $display("[TB] FAIL zero_p2r_count: got %0d want 992", n2r); end
    total_cmp++; if (n_ovl !== 0)  begin bad_cmp++; $display("[TB] FAIL zero_overlap: got %0d want 0", n_ovl); end
    total_cmp++; if (n_sync !== 1 || sync_i !== 0) begin bad_cmp++; $display("[TB] FAIL zero_sync: got count %0d at %0d want 1 at 0", n_sync, sync_i); end
    total_cmp++; if (trace_err !== 0) begin bad_cmp++; $display("[TB] FAIL zero_trace: %0d cycles differ, first at cnt=%0d got=%b want=%b", trace_err, te_cnt, te_obs, te_exp); end
    trace_err = 0;
  endtask

  task automatic test_saturation();
    measure_period(1500, 12'd0, 12'($urandom), -1, -1, -1);
    total_cmp++; if (n1l !== 2015) begin bad_cmp++; $display("[TB] FAIL sat_p1l_count: got %0d want 2015", n1l); end
    total_cmp++; if (l1l !== 2046) begin bad_cmp++; $display("[TB] FAIL sat_p1l_last: got %0d want 2046", l1l); end
    total_cmp++; if (n2l !== 0)    begin bad_cmp++; $display("[TB] FAIL sat_p2l_count: got %0d want 0", n2l); end
    total_cmp++; if (n1r !== 0)    begin bad_cmp++; $display("[TB] FAIL sat_p1r_count: got %0d want 0", n1r); end
    total_cmp++; if (n2r !== 2016 || f2r !== 32 || l2r !== 2047) begin bad_cmp++; $display("[TB] FAIL sat_p2r_window: got %0d high from %0d to %0d want 2016 from 32 to 2047", n2r, f2r, l2r); end
    total_cmp++; if (n_ovl !== 0)  begin bad_cmp++; $display("[TB] FAIL sat_overlap: got %0d want 0", n_ovl); end
    total_cmp++; if (trace_err !== 0) begin bad_cmp++; $display("[TB] FAIL sat_trace: %0d cycles differ, first at cnt=%0d got=%b want=%b", trace_err, te_cnt, te_obs, te_exp); end
    trace_err = 0;
  endtask

  task automatic test_mid_change();
    measure_period(600, 12'd500, 12'($urandom), -1, -1, -1);
    total_cmp++; if (l1l !== 1023) begin bad_cmp++; $display("[TB] FAIL mid_cur_p1l_last: got %0d want 1023", l1l); end
    measure_period(1800, 12'd0, 12'($urandom), -1, -1, -1);
    total_cmp++; if (l1l !== 1523) begin bad_cmp++; $display("[TB] FAIL mid_next_p1l_last: got %0d want 1523", l1l); end
    total_cmp++; if (n1l !== 1492) begin bad_cmp++; $display("[TB] FAIL mid_next_p1l_count: got %0d want 1492", n1l); end
    total_cmp++; if (n2l !== 492)  begin bad_cmp++; $display("[TB] FAIL mid_next_p2l_count: got %0d want 492", n2l); end
    total_cmp++; if (trace_err !== 0) begin bad_cmp++; $display("[TB] FAIL mid_trace: %0d cycles differ, first at cnt=%0d got=%b want=%b", trace_err, te_cnt, te_obs, te_exp); end
    trace_err = 0;
  endtask

  // 15 faulty periods, one clean period holding only blanked/off-time pulses,
  // then 16 faulty periods: shutdown must appear only after the last boundary.
  task automatic test_overcurrent();
    int sh_early, pwm_on, sh_off;
    sh_early = 0;
    for (int p = 0; p < 15; p++) begin
      measure_period(1000, 12'd0, 12'($urandom), 500, 100, 100);
      sh_early += n_sh;
    end
    measure_period(1000, 12'd0, 12'($urandom), 100, 1500, 100);
    sh_early += n_sh;
    for (int p = 0; p < 16; p++) begin
      measure_period(1000, 12'd0, 12'($urandom), 500, 100, 100);
      sh_early += n_sh;
    end
    total_cmp++; if (sh_early !== 0) begin bad_cmp++; $display("[TB] FAIL ovr_no_early_shutdown: got %0d cycles with shutdown want 0", sh_early); end
    tick();
    total_cmp++; if (OVR_I_shtdwn !== 1'b1) begin bad_cmp++; $display("[TB] FAIL ovr_shutdown_set: got %b want 1", OVR_I_shtdwn); end
    total_cmp++; if ({PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght} !== 4'b0) begin bad_cmp++; $display("[TB] FAIL ovr_pwm_off: got %b want 0000", {PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght}); end
    total_cmp++; if (PWM_synch !== 1'b1) begin bad_cmp++; $display("[TB] FAIL ovr_synch_running: got %b want 1", PWM_synch); end
    pwm_on = 0; sh_off = 0;
    for (int i = 0; i < 299; i++) begin
      tick();
      if (PWM1_lft || PWM2_lft || PWM1_rght || PWM2_rght) pwm_on++;
      if (!OVR_I_shtdwn) sh_off++;
    end
    total_cmp++; if (pwm_on !== 0 || sh_off !== 0) begin bad_cmp++; $display("[TB] FAIL ovr_sticky: got %0d pwm-on and %0d flag-low cycles want 0 and 0", pwm_on, sh_off); end
    total_cmp++; if (trace_err !== 0) begin bad_cmp++; $display("[TB] FAIL ovr_trace: %0d cycles differ, first at cnt=%0d got=%b want=%b", trace_err, te_cnt, te_obs, te_exp); end
    trace_err = 0;
  endtask

  task automatic test_reset_mid_period();
    rst_n = 1'b0;
    repeat (2) tick();
    total_cmp++; if (obs_vec() !== 6'b0) begin bad_cmp++; $display("[TB] FAIL rst_clears_shutdown: got %b want 000000", obs_vec()); end
    rst_n = 1'b1;
    repeat (900) tick();
    total_cmp++; if (PWM1_lft !== 1'b1) begin bad_cmp++; $display("[TB] FAIL rst_pwm1_before: got %b want 1", PWM1_lft); end
    lft_spd = 12'hC00; rght_spd = 12'h800;
    rst_n = 1'b0;
    tick();
    total_cmp++; if (obs_vec() !== 6'b0) begin bad_cmp++; $display("[TB] FAIL rst_mid_outputs: got %b want 000000", obs_vec()); end
    rst_n = 1'b1;
    measure_period(-1, 12'd0, 12'd0, -1, -1, -1);
    total_cmp++; if (sync_i !== 0 || n_sync !== 1) begin bad_cmp++; $display("[TB] FAIL rst_cnt_restart: got sync count %0d at %0d want 1 at 0", n_sync, sync_i); end
    total_cmp++; if (n1l !== 992 || n2r !== 992) begin bad_cmp++; $display("[TB] FAIL rst_default_duty: got p1l=%0d p2r=%0d want 992 992", n1l, n2r); end
    total_cmp++; if (trace_err !== 0) begin bad_cmp++; $display("[TB] FAIL rst_trace: %0d cycles differ, first at cnt=%0d got=%b want=%b", trace_err, te_cnt, te_obs, te_exp); end
    trace_err = 0;
  endtask

  initial begin
    m_cnt = 0; m_dl = 1024; m_dr = 1024; m_run = 0;
    m_fault = 1'b0; m_shut = 1'b0;
    {e_p1l, e_p2l, e_p1r, e_p2r, e_sync} = '0;
    test_reset();
    test_zero_speed();
    test_saturation();
    test_mid_change();
    test_overcurrent();
    test_reset_mid_period();
    $display("test done: total=%0d bad=%0d", total_cmp, bad_cmp);
    $finish;
  end

endmodule

// File: doc/mtr_drv.md
Name: mtr_drv

Overview:
- Motor-drive back end of the Segway datapath. Consumes the signed left/right wheel speed commands from the balance controller and produces non-overlapping high/low-side PWM pairs for two H-bridge half-legs.
- Also monitors per-bridge over-current comparators with leading-edge blanking, and latches a shutdown after persistent faults.
- Sits between the balance controller and the board's gate drivers.

Parameters:
- NONOVERLAP, 11'h020: dead-time in clocks between one side falling and the other side rising.
- BLANK, 128: clocks after a high-side rising edge during which OVR_I is ignored.
- OVR_LIMIT, 16: number of consecutive PWM periods containing a qualified over-current event that forces shutdown.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- lft_spd  input  12  signed left wheel speed command
- rght_spd  input  12  signed right wheel speed command
- OVR_I_lft  input  1  left bridge over-current comparator, active high
- OVR_I_rght  input  1  right bridge over-current comparator, active high
- PWM1_lft  output  1  left high-side drive
- PWM2_lft  output  1  left low-side drive
- PWM1_rght  output  1  right high-side drive
- PWM2_rght  output  1  right low-side drive
- PWM_synch  output  1  one-clock pulse at the start of each PWM period
- OVR_I_shtdwn  output  1  sticky over-current shutdown flag

Behaviour:
- Reset: synchronous, active-low, sampled on posedge clk. While rst_n=0:
  - cnt=0, both duty registers=1024, ovr_seen=0, ocnt=0, shutdown=0.
  - All PWM outputs, PWM_synch and OVR_I_shtdwn are 0.
  - Reset asserted mid-period takes effect on the next edge; there is no partial-period completion.
- Period counter cnt: 11-bit unsigned, free-running, increments by 1 each clock and wraps 2047->0. Period is 2048 clocks; left and right share one counter.
- PWM_synch is registered, high for exactly one clock when cnt==0. It is not asserted during reset.
- Duty computation, per side:
  - Saturate spd to the range [-1024, +1023].
  - duty = sat + 1024, an unsigned 11-bit value in 0..2047.
  - duty is captured into the side's duty register only when cnt==2047, so it applies to the whole next period.
  - spd changes mid-period have no effect until the next boundary.
- PWM generation, registered, one-clock latency from the cnt decode:
  - PWM1 = (cnt >= NONOVERLAP) && (cnt < duty_reg).
  - PWM2 = (cnt >= duty_reg + NONOVERLAP). Compute this sum in 12 bits; if it exceeds 2047, PWM2 stays 0 for the period.
  - PWM1 and PWM2 of a side are never high in the same cycle. Any high-to-high transition has at least NONOVERLAP low clocks between the two pulses, including across the period wrap.
  - Boundary cases: duty <= NONOVERLAP means PWM1 is never high; duty=0 means PWM2 is high for cnt 32..2047 (default NONOVERLAP).
- Over-current qualification: OVR_I_x is qualified only when PWM1_x==1 and cnt >= NONOVERLAP+BLANK. Assertions at other times are ignored.
- Fault accumulation:
  - ovr_seen is set by a qualified event from either side.
  - At cnt==2047: if ovr_seen is set (or an event qualifies this cycle), ocnt increments, saturating; otherwise ocnt clears to 0. ovr_seen then clears.
  - When ocnt reaches OVR_LIMIT, shutdown sets on the next clock.
- Shutdown:
  - All four PWM outputs are forced to 0 and OVR_I_shtdwn=1.
  - The counter and PWM_synch keep running.
  - Only rst_n clears shutdown.

Decomposition:
- Package mtr_drv_pkg holds:
  - PWM_W=11.
  - PWM_MID=11'd1024.
  - SPD_MAX=+1023 and SPD_MIN=-1024.
  - A function sat_spd(signed [11:0]) returning signed [10:0].
- Sub-module pwm_dt, instantiated once per side:
  - Inputs: clk, rst_n, cnt, spd, shtdwn.
  - Outputs: PWM1, PWM2, qualified over-current event.
  - Contains the duty register and the dead-time compare.
- The top level owns cnt, PWM_synch, ovr_seen, ocnt and the shutdown latch.

Test Plan:
- spd=0 both sides -> PWM1 high for 992 clks (cnt 32..1023), PWM2 high for 992 clks (cnt 1056..2047), no overlap; PWM_synch period is 2048.
- lft_spd=+1023, rght_spd=-2048 -> left: PWM1 2015 clks, PWM2 never. Right saturates to duty 0: PWM1 never, PWM2 high cnt 32..2047.
- lft_spd changed 0->500 at cnt=600 -> current period PWM1 still falls at cnt=1024; next period PWM1 falls at cnt=1524.
- OVR_I_lft pulsed at cnt=100 (blanked) in 20 periods -> no shutdown. Pulsed at cnt=500 in 16 consecutive periods -> OVR_I_shtdwn=1 just after the 16th boundary, all PWM outputs 0 until rst_n.
- 15 fault periods, 1 clean period, 15 fault periods -> OVR_I_shtdwn stays 0.
- rst_n low at cnt=900 with PWM1 high -> next edge: all outputs 0, cnt=0. After release, the first period uses duty 1024.
